// File: rtl/solar_pkg.sv
// ============================================================================
//  Module      : solar_pkg
//  Description : Shared constants for the solar panel monitor register block:
//                register word offsets, CTRL/STATUS bit positions, ID value
//                and the Wishbone responder state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package solar_pkg;

    // Word offsets (byte offset >> 2), compared against wbs_adr_i[7:2]
    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_THRESH = 6'h01;
    localparam logic [5:0] REG_STATUS = 6'h02;
    localparam logic [5:0] REG_DATA   = 6'h03;
    localparam logic [5:0] REG_ID     = 6'h04;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    // STATUS bit positions
    localparam int STAT_CNT_W = 4;
    localparam int STAT_EMPTY = 4;
    localparam int STAT_FULL  = 5;
    localparam int STAT_OVF   = 6;
    localparam int STAT_BELOW = 7;

    localparam logic [31:0] SOLAR_ID = 32'h534F_4C31;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/solar_sample_fifo.sv
// ============================================================================
//  Module      : solar_sample_fifo
//  Description : Power-of-two sample FIFO with synchronous clear and
//                simultaneous push/pop. A pop on empty is ignored; a push on
//                full only lands if a pop frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module solar_sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // Pointer and occupancy tracking; clear overrides any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are only observed through a non-empty read
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/solar_wb_regs.sv
// ============================================================================
//  Module      : solar_wb_regs
//  Description : Wishbone classic register responder for the solar panel
//                monitor: CTRL/THRESH/STATUS/DATA/ID registers, 8-entry
//                sample FIFO, sticky overflow/below flags and interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module solar_wb_regs
    import solar_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          SAMPLE_W   = 12
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic                sample_valid_i,
    input  logic [SAMPLE_W-1:0] sample_data_i,
    input  logic [1:0]          sample_ch_i,
    output logic                ctrl_en_o,
    output logic [SAMPLE_W-1:0] ctrl_thresh_o,
    output logic                irq_o
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = SAMPLE_W + 2;

    wb_state_t            state;
    wb_state_t            next_state;
    logic                 hit;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [5:0]           offset;
    logic                 ctrl_en;
    logic                 irq_en;
    logic [SAMPLE_W-1:0]  thresh;
    logic                 ovf;
    logic                 below;
    logic                 fifo_clr;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 sample_fits;
    logic                 set_ovf;
    logic                 set_below;
    logic                 w1c_ovf;
    logic                 w1c_below;
    logic [31:0]          rd_mux;
    logic                 unused_ok;

    assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign offset = wbs_adr_i[7:2];
    assign accept = (state == ST_IDLE) & wbs_stb_i & wbs_cyc_i & hit;
    assign wr_acc = accept & wbs_we_i;
    assign rd_acc = accept & ~wbs_we_i;

    // fifo_clear is a pulse taken straight from the write; nothing is stored
    assign fifo_clr  = wr_acc & (offset == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_CLEAR];
    assign fifo_push = ctrl_en & sample_valid_i;
    assign fifo_pop  = rd_acc & (offset == REG_DATA);

    // A push lands if there is room or a real pop frees a slot this cycle
    assign sample_fits = ~fifo_full | (fifo_pop & ~fifo_empty);
    assign set_ovf     = fifo_push & ~sample_fits & ~fifo_clr;
    assign set_below   = fifo_push & sample_fits & ~fifo_clr & (sample_data_i < thresh);
    assign w1c_ovf     = wr_acc & (offset == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_OVF];
    assign w1c_below   = wr_acc & (offset == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_BELOW];

    assign wbs_ack_o     = (state == ST_ACK);
    assign ctrl_en_o     = ctrl_en;
    assign ctrl_thresh_o = thresh;

    // Address/sel/data bits that no register field consumes
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i};

    solar_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({sample_ch_i, sample_data_i}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Responder state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= ST_IDLE;
        else            state <= next_state;
    end

    // Responder next state: accept in IDLE, always one cycle of ACK
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (wbs_stb_i && wbs_cyc_i && hit) next_state = ST_ACK;
            ST_ACK:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Read data selection from pre-edge register and FIFO state
    always_comb begin
        rd_mux = '0;
        case (offset)
            REG_CTRL: begin
                rd_mux[CTRL_EN]     = ctrl_en;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            REG_THRESH: rd_mux[SAMPLE_W-1:0] = thresh;
            REG_STATUS: begin
                rd_mux[STAT_CNT_W-1:0] = STAT_CNT_W'(fifo_count);
                rd_mux[STAT_EMPTY]     = fifo_empty;
                rd_mux[STAT_FULL]      = fifo_full;
                rd_mux[STAT_OVF]       = ovf;
                rd_mux[STAT_BELOW]     = below;
            end
            REG_DATA:   if (!fifo_empty) rd_mux[ENTRY_W-1:0] = fifo_rdata;
            REG_ID:     rd_mux = SOLAR_ID;
            default:    rd_mux = '0;
        endcase
    end

    // Control registers with per-byte write enables
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ctrl_en <= 1'b0;
            irq_en  <= 1'b0;
            thresh  <= '0;
        end else if (wr_acc) begin
            if (offset == REG_CTRL && wbs_sel_i[0]) begin
                ctrl_en <= wbs_dat_i[CTRL_EN];
                irq_en  <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (offset == REG_THRESH) begin
                if (wbs_sel_i[0]) thresh[7:0]          <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) thresh[SAMPLE_W-1:8] <= wbs_dat_i[SAMPLE_W-1:8];
            end
        end
    end

    // Sticky flags: a set event in the same cycle beats write-one-to-clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ovf   <= 1'b0;
            below <= 1'b0;
        end else begin
            ovf   <= (ovf & ~w1c_ovf) | set_ovf;
            below <= (below & ~w1c_below) | set_below;
        end
    end

    // Read data capture on the accept edge (pop happens on the same edge)
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)  wbs_dat_o <= '0;
        else if (accept) wbs_dat_o <= wbs_we_i ? 32'h0 : rd_mux;
    end

    // Interrupt follows the registered flags one cycle later
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) irq_o <= 1'b0;
        else            irq_o <= irq_en & (ovf | below);
    end

endmodule

`default_nettype wire
